// File: rtl/autocorr_pkg.sv
// rtl/autocorr_pkg.sv - shared state type and width helpers for the autocorrelation scheduler
package autocorr_pkg;

   typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, DONE} acf_state_t;

   // Worst-case sum of FRAME_LEN full-scale products fits without saturation
   function automatic int acc_width(input int data_width, input int frame_len);
      return 2 * data_width + $clog2(frame_len);
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/autocorr_mac.sv
// rtl/autocorr_mac.sv - registered signed multiply followed by accumulate with first-term clear
module autocorr_mac #(
   parameter int DATA_WIDTH = 12,
   parameter int ACC_WIDTH  = 34
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic                         in_first,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext, acc_base;
   logic                           prod_valid, prod_first;

   always_comb begin
      a_ext    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      b_ext    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
      prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      acc_base = prod_first ? '0 : acc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod       <= '0;
         prod_valid <= 1'b0;
         prod_first <= 1'b0;
         acc        <= '0;
      end else begin
         prod       <= a_ext * b_ext;
         prod_valid <= in_valid;
         prod_first <= in_first;
         if (prod_valid) begin
            acc <= acc_base + prod_ext;
         end
      end
   end

endmodule

// File: rtl/autocorr_frame_sched.sv
// rtl/autocorr_frame_sched.sv - frame capture and time-multiplexed autocorrelation peak search
module autocorr_frame_sched
   import autocorr_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int FRAME_LEN  = 1024,
   parameter int MAX_TAU    = 256,
   parameter int MIN_TAU    = 10,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, FRAME_LEN)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         start,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] sample_data,
   output logic                         busy,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic [15:0]                  period,
   output logic signed [ACC_WIDTH-1:0]  peak_corr,
   output logic                         no_peak,
   output logic                         stable,
   output logic                         overrun
);

   localparam int IDX_W = idx_width(FRAME_LEN);
   localparam int CNT_W = IDX_W + 1;

   acf_state_t state_q, state_d;

   logic [IDX_W-1:0]             wr_idx;
   logic [IDX_W-1:0]             tau;
   logic [CNT_W-1:0]             cnt, lag_len;
   logic [IDX_W-1:0]             k_a, k_b;
   logic signed [DATA_WIDTH-1:0] frame_buf [FRAME_LEN];
   logic signed [DATA_WIDTH-1:0] rd_a, rd_b;
   logic                         issue, rd_valid, rd_first;
   logic                         cap_last, lag_end, last_lag, accept, upd;
   logic signed [ACC_WIDTH-1:0]  acc, best, fin_best;
   logic [15:0]                  best_tau, fin_tau;
   logic [15:0]                  hist [2];
   logic [1:0]                   hist_cnt;
   logic [15:0]                  h_new [3];
   logic [15:0]                  h_max, h_min;
   logic                         h_nz, stable_d;

   // cnt walks issue slots 0..lag_len-1, then two drain cycles, then the compare cycle
   always_comb begin
      lag_len  = CNT_W'(FRAME_LEN) - CNT_W'(tau);
      issue    = (state_q == COMPUTE) && (cnt < lag_len);
      lag_end  = (state_q == COMPUTE) && (cnt == lag_len + CNT_W'(2));
      last_lag = (tau == IDX_W'(MAX_TAU - 1));
      cap_last = (state_q == CAPTURE) && sample_valid && (wr_idx == IDX_W'(FRAME_LEN - 1));
      accept   = result_valid && result_ready;
      k_a      = tau + cnt[IDX_W-1:0];
      k_b      = cnt[IDX_W-1:0];
      upd      = (acc > best);
      fin_best = upd ? acc : best;
      fin_tau  = upd ? 16'(tau) : best_tau;
   end

   always_comb begin
      h_new[0] = fin_tau;
      h_new[1] = hist[0];
      h_new[2] = hist[1];
      h_max    = h_new[0];
      h_min    = h_new[0];
      h_nz     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (h_new[i] > h_max) h_max = h_new[i];
         if (h_new[i] < h_min) h_min = h_new[i];
         if (h_new[i] == 16'd0) h_nz = 1'b0;
      end
      stable_d = (hist_cnt == 2'd2) && h_nz && ((h_max - h_min) <= (h_new[0] >> 5));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q == CAPTURE) || (state_q == COMPUTE);
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start)               state_d = CAPTURE;
            CAPTURE: if (cap_last)            state_d = COMPUTE;
            COMPUTE: if (lag_end && last_lag) state_d = DONE;
            DONE:    if (accept)              state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == CAPTURE) && sample_valid) begin
         frame_buf[wr_idx] <= sample_data;
      end
      rd_a <= frame_buf[k_a];
      rd_b <= frame_buf[k_b];
   end

   autocorr_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (rd_valid),
      .in_first (rd_first),
      .a        (rd_a),
      .b        (rd_b),
      .acc      (acc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_idx       <= '0;
         tau          <= '0;
         cnt          <= '0;
         rd_valid     <= 1'b0;
         rd_first     <= 1'b0;
         best         <= '0;
         best_tau     <= '0;
         result_valid <= 1'b0;
         period       <= '0;
         peak_corr    <= '0;
         no_peak      <= 1'b0;
         stable       <= 1'b0;
         overrun      <= 1'b0;
         hist_cnt     <= '0;
         for (int i = 0; i < 2; i++) hist[i] <= '0;
      end else begin
         rd_valid <= issue;
         rd_first <= issue && (cnt == '0);
         if (!en) begin
            // Abort behaves like reset but keeps the stability history
            result_valid <= 1'b0;
            period       <= '0;
            peak_corr    <= '0;
            no_peak      <= 1'b0;
            overrun      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     wr_idx  <= '0;
                     overrun <= 1'b0;
                  end
               end
               CAPTURE: begin
                  if (sample_valid) wr_idx <= wr_idx + IDX_W'(1);
                  if (cap_last) begin
                     tau      <= IDX_W'(MIN_TAU);
                     cnt      <= '0;
                     best     <= '0;
                     best_tau <= '0;
                  end
               end
               COMPUTE: begin
                  if (sample_valid) overrun <= 1'b1;
                  if (lag_end) begin
                     best     <= fin_best;
                     best_tau <= fin_tau;
                     cnt      <= '0;
                     tau      <= tau + IDX_W'(1);
                     if (last_lag) begin
                        result_valid <= 1'b1;
                        period       <= fin_tau;
                        peak_corr    <= fin_best;
                        no_peak      <= (fin_best == '0);
                        stable       <= stable_d;
                        hist[0]      <= fin_tau;
                        hist[1]      <= hist[0];
                        if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               DONE: begin
                  if (sample_valid) overrun <= 1'b1;
                  if (accept) result_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_autocorr_frame_sched.sv
// tb/tb_autocorr_frame_sched.sv - randomized bench against a direct autocorrelation reference model
module tb_autocorr_frame_sched;

   localparam int DW   = 12;
   localparam int N    = 128;
   localparam int MAXT = 64;
   localparam int MINT = 10;
   localparam int ACCW = 2 * DW + 7;

   logic                   clk = 1'b0;
   logic                   rst_n, en, start, sample_valid, result_ready;
   logic signed [DW-1:0]   sample_data;
   logic                   busy, result_valid, no_peak, stable, overrun;
   logic [15:0]            period;
   logic signed [ACCW-1:0] peak_corr;

   int tests_run    = 0;
   int tests_failed = 0;
   int frame [N];
   int hist_q [$];

   autocorr_frame_sched #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (N),
      .MAX_TAU    (MAXT),
      .MIN_TAU    (MINT),
      .ACC_WIDTH  (ACCW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .start        (start),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .period       (period),
      .peak_corr    (peak_corr),
      .no_peak      (no_peak),
      .stable       (stable),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // r[tau] straight from the definition; history kept as a queue of periods
   task automatic model_frame(output int p, output longint pk, output bit np, output bit st);
      longint best, r;
      int     bt, mx, mn;
      bit     nz;
      best = 0;
      bt   = 0;
      for (int t = MINT; t < MAXT; t++) begin
         r = 0;
         for (int k = t; k < N; k++) r += longint'(frame[k]) * longint'(frame[k-t]);
         if (r > best) begin
            best = r;
            bt   = t;
         end
      end
      hist_q.push_front(bt);
      if (hist_q.size() > 3) void'(hist_q.pop_back());
      st = 1'b0;
      if (hist_q.size() == 3) begin
         mx = hist_q[0];
         mn = hist_q[0];
         nz = 1'b1;
         foreach (hist_q[i]) begin
            if (hist_q[i] > mx) mx = hist_q[i];
            if (hist_q[i] < mn) mn = hist_q[i];
            if (hist_q[i] == 0) nz = 1'b0;
         end
         st = nz && ((mx - mn) <= (hist_q[0] / 32));
      end
      p  = bt;
      pk = best;
      np = (best == 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   task automatic fill_sine(input int per);
      real ph;
      for (int i = 0; i < N; i++) begin
         ph       = 6.283185307179586 * real'(i) / real'(per);
         frame[i] = $rtoi(1500.0 * $sin(ph));
      end
   endtask

   task automatic capture(input bit junk_with_start);
      start = 1'b1;
      if (junk_with_start) begin
         sample_valid = 1'b1;
         sample_data  = DW'(2047);
      end
      cyc();
      start        = 1'b0;
      sample_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         sample_valid = 1'b1;
         sample_data  = DW'(frame[i]);
         cyc();
         sample_valid = 1'b0;
         if (i < N - 1) repeat ($urandom_range(0, 1)) cyc();
      end
   endtask

   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (!result_valid && n < 20000) begin
         cyc();
         n++;
      end
      check({tag, "_done"}, longint'(result_valid), 1);
   endtask

   task automatic check_result(input string tag);
      int     p;
      longint pk;
      bit     np, st;
      model_frame(p, pk, np, st);
      check({tag, "_period"}, period, p);
      check({tag, "_peak"}, peak_corr, pk);
      check({tag, "_no_peak"}, no_peak, np);
      check({tag, "_stable"}, stable, st);
      repeat ($urandom_range(1, 4)) cyc();
      check({tag, "_held_valid"}, result_valid, 1);
      check({tag, "_held_period"}, period, p);
      result_ready = 1'b1;
      cyc();
      result_ready = 1'b0;
      check({tag, "_valid_drop"}, result_valid, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      bit seen;
      rst_n        = 1'b0;
      en           = 1'b0;
      start        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      result_ready = 1'b0;
      repeat (3) cyc();
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_period", period, 0);
      check("rst_peak", peak_corr, 0);
      check("rst_no_peak", no_peak, 0);
      check("rst_stable", stable, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      en    = 1'b1;
      cyc();

      // square wave period 20, with a junk strobe on the start cycle
      for (int i = 0; i < N; i++) frame[i] = (((i / 10) % 2) == 0) ? 1000 : -1000;
      capture(1'b1);
      check("sq_busy", busy, 1);
      wait_result("sq");
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("sq_start_ignored", result_valid, 1);
      check("sq_period_20", period, 20);
      check_result("sq");

      // three identical period-32 sines then a period-50 sine
      for (int f = 0; f < 4; f++) begin
         fill_sine((f < 3) ? 32 : 50);
         capture(1'b0);
         wait_result("sine");
         if (f == 2) check("sine_stable_f3", stable, 1);
         if (f == 3) check("sine_unstable_f4", stable, 0);
         check_result("sine");
      end

      for (int i = 0; i < N; i++) frame[i] = 0;
      capture(1'b0);
      wait_result("zero");
      check("zero_no_peak", no_peak, 1);
      check("zero_period", period, 0);
      check("zero_peak", peak_corr, 0);
      check_result("zero");

      fill_random();
      capture(1'b0);
      check("ovr_pre", overrun, 0);
      repeat (300) cyc();
      sample_valid = 1'b1;
      sample_data  = DW'($urandom);
      cyc();
      sample_valid = 1'b0;
      check("ovr_set", overrun, 1);
      check("ovr_busy", busy, 1);
      wait_result("ovr");
      check("ovr_sticky", overrun, 1);
      check_result("ovr");

      // abort partway through lag 20
      fill_random();
      capture(1'b0);
      check("ovr_cleared", overrun, 0);
      repeat (1165 + 50) cyc();
      en = 1'b0;
      cyc();
      check("abort_busy", busy, 0);
      check("abort_valid", result_valid, 0);
      en   = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cyc();
         seen |= result_valid;
      end
      check("abort_no_result", seen, 0);

      // equal r at lags 30 and 60
      for (int i = 0; i < N; i++) frame[i] = 0;
      frame[0]  = 200;
      frame[30] = 100;
      frame[60] = 200;
      capture(1'b0);
      wait_result("tie");
      check("tie_period_30", period, 30);
      check("tie_peak", peak_corr, 40000);
      check_result("tie");

      fill_random();
      capture(1'b0);
      wait_result("rst");
      rst_n = 1'b0;
      cyc();
      check("rstd_busy", busy, 0);
      check("rstd_valid", result_valid, 0);
      check("rstd_period", period, 0);
      check("rstd_peak", peak_corr, 0);
      check("rstd_no_peak", no_peak, 0);
      check("rstd_stable", stable, 0);
      check("rstd_overrun", overrun, 0);
      rst_n = 1'b1;
      hist_q.delete();
      cyc();

      fill_random();
      capture(1'b0);
      wait_result("post_rst");
      check_result("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
